ps2_kbd_cmd_seq: RTL and testbench

- Host-to-keyboard command sequencer for the PS/2 keyboard path.
- After reset it resets the keyboard (0xFF, waits for 0xFA and then the BAT byte 0xAA).
- Afterwards it serves LED-update requests (0xED + argument), with per-byte acknowledge, timeout and retry.
- Sits between the PS/2 receiver/transmitter and the key translator. It swallows protocol bytes (FA/FE/AA/EE) so only scan codes reach the translator.

---
 rtl/ps2_kbd_cmd_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ps2_kbd_cmd_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_cmd_seq.sv
// ps2_kbd_cmd_seq: host-to-keyboard command sequencer for the PS/2 keyboard path.
// It resets the keyboard (FF, then waits for FA and the BAT byte AA) and then serves
// LED updates (ED + argument). Each byte is acknowledged, with timeout and resend.
// Protocol bytes are swallowed, so only scan codes reach the key translator.
// Ports:
//   mclk, reset_n          clock, async active-low reset
//   rx_dav/rx_code         byte from the PS/2 receiver
//   tx_busy/tx_done        transmitter status; tx_start/tx_data start a byte send
//   led_req/led_val        LED update request {caps,num,scroll}; led_ack/led_err = completion
//   init_done/kbd_fail     keyboard reset completed / retries exhausted (sticky)
//   filt_dav/filt_code     filtered scan-code strobe and byte
module ps2_kbd_cmd_seq #(
    parameter int unsigned TO_W      = 20,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic       rx_dav,
    input  logic [7:0] rx_code,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       led_ack,
    output logic       led_err,
    output logic       init_done,
    output logic       kbd_fail,
    output logic       filt_dav,
    output logic [7:0] filt_code
);

    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [7:0] B_FF = 8'hFF;
    localparam logic [7:0] B_ED = 8'hED;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_FE = 8'hFE;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_EE = 8'hEE;
    localparam logic [7:0] B_FC = 8'hFC;

    typedef enum logic [3:0] {
        S_RST_CMD, S_WAIT_ACK0, S_WAIT_BAT, S_READY, S_LED_CMD,
        S_WAIT_ACK1, S_LED_ARG, S_WAIT_ACK2, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;       // 0: waiting for idle tx, 1: waiting for tx_done
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic              pending_q, pending_d;
    logic [2:0]        shadow_q, shadow_d;
    logic              req_act_q, req_act_d;   // current LED sequence was request-initiated
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              led_ack_q, led_ack_d;
    logic              led_err_q, led_err_d;
    logic              init_done_q, init_done_d;
    logic              kbd_fail_q, kbd_fail_d;
    logic              filt_dav_q, filt_dav_d;
    logic [7:0]        filt_code_q, filt_code_d;

    logic              rx_fa, rx_fe, rx_aa, rx_fc, rx_proto, timeout;
    logic              retry_evt;
    logic [7:0]        send_byte;
    state_t            send_next, resend_st;

    assign rx_fa    = rx_dav && (rx_code == B_FA);
    assign rx_fe    = rx_dav && (rx_code == B_FE);
    assign rx_aa    = rx_dav && (rx_code == B_AA);
    assign rx_fc    = rx_dav && (rx_code == B_FC);
    assign rx_proto = (rx_code == B_FA) || (rx_code == B_FE) || (rx_code == B_AA) || (rx_code == B_EE);
    assign timeout  = &timer_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        retry_d     = retry_q;
        timer_d     = '0;
        pending_d   = pending_q;
        shadow_d    = shadow_q;
        req_act_d   = req_act_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        led_ack_d   = 1'b0;
        led_err_d   = 1'b0;
        init_done_d = init_done_q;
        kbd_fail_d  = kbd_fail_q;
        filt_dav_d  = 1'b0;
        filt_code_d = filt_code_q;
        send_byte   = B_FF;
        send_next   = S_WAIT_ACK0;
        resend_st   = S_RST_CMD;
        retry_evt   = 1'b0;

        // Requests arriving while busy are coalesced; the last value wins
        if (led_req && (state_q != S_READY) && (state_q != S_FAIL)) begin
            pending_d = 1'b1;
            shadow_d  = led_val;
        end

        case (state_q)
            S_RST_CMD: begin
                send_byte = B_FF;
                send_next = S_WAIT_ACK0;
            end
            S_LED_CMD: begin
                send_byte = B_ED;
                send_next = S_WAIT_ACK1;
            end
            S_LED_ARG: begin
                send_byte = {5'b0, shadow_q};
                send_next = S_WAIT_ACK2;
            end
            S_WAIT_ACK0: begin
                resend_st = S_RST_CMD;
                if (rx_fa) begin
                    retry_d = '0;
                    state_d = S_WAIT_BAT;
                end else begin
                    retry_evt = rx_fe || timeout;
                end
            end
            S_WAIT_BAT: begin
                resend_st = S_RST_CMD;
                if (rx_aa) begin
                    retry_d     = '0;
                    init_done_d = 1'b1;
                    state_d     = S_READY;
                end else if (rx_fc) begin
                    state_d = S_FAIL;
                end else begin
                    retry_evt = rx_fe || timeout;
                end
            end
            S_WAIT_ACK1: begin
                resend_st = S_LED_CMD;
                if (rx_fa) begin
                    retry_d = '0;
                    state_d = S_LED_ARG;
                end else begin
                    retry_evt = rx_fe || timeout;
                end
            end
            S_WAIT_ACK2: begin
                resend_st = S_LED_ARG;
                if (rx_fa) begin
                    retry_d   = '0;
                    led_ack_d = req_act_q;
                    req_act_d = 1'b0;
                    state_d   = S_READY;
                end else begin
                    retry_evt = rx_fe || timeout;
                end
            end
            S_READY: begin
                if (rx_dav && !rx_proto) begin
                    filt_dav_d  = 1'b1;
                    filt_code_d = rx_code;
                end
                if (pending_q || led_req) begin
                    if (led_req) begin
                        shadow_d = led_val;
                    end
                    pending_d = 1'b0;
                    req_act_d = 1'b1;
                    state_d   = S_LED_CMD;
                end else if (rx_aa) begin
                    // Keyboard self-reset: restore LEDs silently
                    req_act_d = 1'b0;
                    state_d   = S_LED_CMD;
                end
            end
            S_FAIL: begin
                if (led_req) begin
                    led_ack_d = 1'b1;
                    led_err_d = 1'b1;
                end
            end
            default: state_d = S_RST_CMD;
        endcase

        // Shared send micro-sequence for the command/argument states
        if (state_q inside {S_RST_CMD, S_LED_CMD, S_LED_ARG}) begin
            if (!phase_q) begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = send_byte;
                    phase_d    = 1'b1;
                end
            end else if (tx_done) begin
                phase_d = 1'b0;
                state_d = send_next;
            end
        end

        // Saturating response timer, only while waiting
        if (state_q inside {S_WAIT_ACK0, S_WAIT_BAT, S_WAIT_ACK1, S_WAIT_ACK2}) begin
            timer_d = timeout ? timer_q : timer_q + TO_W'(1);
        end

        if (retry_evt) begin
            if (retry_q >= RTY_W'(MAX_RETRY)) begin
                state_d = S_FAIL;
            end else begin
                retry_d = retry_q + RTY_W'(1);
                state_d = resend_st;
            end
        end

        if (state_d == S_FAIL) begin
            kbd_fail_d  = 1'b1;
            init_done_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RST_CMD;
            phase_q     <= 1'b0;
            retry_q     <= '0;
            timer_q     <= '0;
            pending_q   <= 1'b0;
            shadow_q    <= '0;
            req_act_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            led_ack_q   <= 1'b0;
            led_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            kbd_fail_q  <= 1'b0;
            filt_dav_q  <= 1'b0;
            filt_code_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
            req_act_q   <= req_act_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            led_ack_q   <= led_ack_d;
            led_err_q   <= led_err_d;
            init_done_q <= init_done_d;
            kbd_fail_q  <= kbd_fail_d;
            filt_dav_q  <= filt_dav_d;
            filt_code_q <= filt_code_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign led_ack   = led_ack_q;
    assign led_err   = led_err_q;
    assign init_done = init_done_q;
    assign kbd_fail  = kbd_fail_q;
    assign filt_dav  = filt_dav_q;
    assign filt_code = filt_code_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_seq.sv
// tb_ps2_kbd_cmd_seq: directed bench for ps2_kbd_cmd_seq with a small transmitter
// model (3-cycle busy, then tx_done) and hand-computed expected values.
module tb_ps2_kbd_cmd_seq;

    logic       mclk = 1'b0;
    logic       reset_n;
    logic       rx_dav;
    logic [7:0] rx_code;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       led_req;
    logic [2:0] led_val;
    logic       led_ack;
    logic       led_err;
    logic       init_done;
    logic       kbd_fail;
    logic       filt_dav;
    logic [7:0] filt_code;

    ps2_kbd_cmd_seq #(.TO_W(6), .MAX_RETRY(3)) dut (
        .mclk(mclk), .reset_n(reset_n), .rx_dav(rx_dav), .rx_code(rx_code),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .led_req(led_req), .led_val(led_val), .led_ack(led_ack), .led_err(led_err),
        .init_done(init_done), .kbd_fail(kbd_fail), .filt_dav(filt_dav), .filt_code(filt_code)
    );

    always #5 mclk = ~mclk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    int         ack_cnt = 0;
    int         filt_cnt = 0;
    logic       last_err = 1'b0;
    logic [7:0] sent_q[$];
    int         sent_t[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Transmitter model: accept a byte, stay busy 3 cycles, then pulse tx_done
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge mclk);
            #1;
            cyc++;
            tx_done = 1'b0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end else if (tx_start) begin
                sent_q.push_back(tx_data);
                sent_t.push_back(cyc);
                tx_busy  = 1'b1;
                busy_cnt = 3;
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge mclk);
            if (led_ack) begin
                ack_cnt++;
                last_err = led_err;
            end
            if (filt_dav) filt_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic rx(input logic [7:0] code);
        @(negedge mclk);
        rx_dav  = 1'b1;
        rx_code = code;
        @(negedge mclk);
        rx_dav  = 1'b0;
    endtask

    task automatic led(input logic [2:0] v);
        @(negedge mclk);
        led_req = 1'b1;
        led_val = v;
        @(negedge mclk);
        led_req = 1'b0;
    endtask

    // Wait for the next transmitted byte and for its send to complete
    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int n;
        int t;
        logic [7:0] b;
        n = 0;
        while (sent_q.size() == 0 && n < 400) begin
            @(negedge mclk);
            n++;
        end
        if (sent_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            b = sent_q.pop_front();
            t = sent_t.pop_front();
            chk(tag, 32'(b), 32'(exp));
            n = 0;
            while (busy_cnt != 0 && n < 20) begin
                @(negedge mclk);
                n++;
            end
            @(negedge mclk);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        rx_dav  = 1'b0;
        rx_code = 8'h00;
        led_req = 1'b0;
        led_val = 3'b000;
        idle(4);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_kbd_fail", 32'(kbd_fail), 32'd0);
        chk("rst_led_ack", 32'(led_ack), 32'd0);
        chk("rst_filt", 32'({filt_dav, filt_code}), 32'd0);

        // Init with two coalesced LED requests issued while waiting for FA
        reset_n = 1'b1;
        expect_tx("init_ff", 8'hFF);
        led(3'b001);
        led(3'b010);
        rx(8'hFA);
        rx(8'hAA);
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_no_filt", 32'(filt_cnt), 32'd0);
        expect_tx("coal_ed", 8'hED);
        rx(8'hFA);
        expect_tx("coal_arg", 8'h02);
        rx(8'hFA);
        idle(3);
        chk("coal_ack", 32'(ack_cnt), 32'd1);
        chk("coal_err", 32'(last_err), 32'd0);
        idle(30);
        chk("coal_no_more_tx", 32'(sent_q.size()), 32'd0);
        chk("coal_single_ack", 32'(ack_cnt), 32'd1);

        // LED update 101
        led(3'b101);
        expect_tx("led_ed", 8'hED);
        rx(8'hFA);
        expect_tx("led_arg", 8'h05);
        rx(8'hFA);
        idle(3);
        chk("led_ack", 32'(ack_cnt), 32'd2);
        chk("led_err", 32'(last_err), 32'd0);

        // Scan code forwarding with one-cycle latency; protocol byte dropped
        @(negedge mclk);
        rx_dav  = 1'b1;
        rx_code = 8'h1C;
        @(negedge mclk);
        rx_dav  = 1'b0;
        chk("filt_dav", 32'(filt_dav), 32'd1);
        chk("filt_code", 32'(filt_code), 32'h1C);
        idle(2);
        chk("filt_dav_pulse", 32'(filt_dav), 32'd0);
        chk("filt_code_hold", 32'(filt_code), 32'h1C);
        rx(8'hEE);
        idle(2);
        chk("filt_ee_drop", 32'(filt_cnt), 32'd1);

        // Three resends of ED, then success
        led(3'b100);
        expect_tx("rty_ed0", 8'hED);
        for (int i = 0; i < 3; i++) begin
            rx(8'hFE);
            expect_tx("rty_ed_resend", 8'hED);
        end
        rx(8'hFA);
        expect_tx("rty_arg", 8'h04);
        rx(8'hFA);
        idle(3);
        chk("rty_ack", 32'(ack_cnt), 32'd3);
        chk("rty_err", 32'(last_err), 32'd0);
        chk("rty_no_fail", 32'(kbd_fail), 32'd0);

        // Hot-plug: AA in READY restores LEDs without led_ack
        rx(8'hAA);
        expect_tx("hp_ed", 8'hED);
        rx(8'hFA);
        expect_tx("hp_arg", 8'h04);
        rx(8'hFA);
        idle(5);
        chk("hp_no_ack", 32'(ack_cnt), 32'd3);
        chk("hp_no_filt", 32'(filt_cnt), 32'd1);

        // Async reset while waiting for the ED acknowledge
        led(3'b011);
        expect_tx("ar_ed", 8'hED);
        @(negedge mclk);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_tx_data", 32'(tx_data), 32'd0);
        chk("ar_init_done", 32'(init_done), 32'd0);
        chk("ar_filt_code", 32'(filt_code), 32'd0);
        idle(3);
        reset_n = 1'b1;
        expect_tx("ar_ff", 8'hFF);
        rx(8'hFA);
        rx(8'hAA);
        chk("ar_init_done2", 32'(init_done), 32'd1);
        idle(20);
        chk("ar_no_led_seq", 32'(sent_q.size()), 32'd0);

        // Four FE replies to ED exhaust the retries
        led(3'b111);
        expect_tx("f_ed0", 8'hED);
        for (int i = 0; i < 3; i++) begin
            rx(8'hFE);
            expect_tx("f_ed_resend", 8'hED);
        end
        rx(8'hFE);
        idle(2);
        chk("f_kbd_fail", 32'(kbd_fail), 32'd1);
        chk("f_init_done", 32'(init_done), 32'd0);
        idle(20);
        chk("f_no_tx", 32'(sent_q.size()), 32'd0);
        @(negedge mclk);
        led_req = 1'b1;
        led_val = 3'b000;
        @(negedge mclk);
        led_req = 1'b0;
        chk("f_req_ack", 32'({led_ack, led_err}), 32'b11);
        idle(2);
        chk("f_kbd_fail_sticky", 32'(kbd_fail), 32'd1);

        // Timeout: no reply to FF at all
        @(negedge mclk);
        reset_n = 1'b0;
        idle(3);
        sent_q.delete();
        sent_t.delete();
        reset_n = 1'b1;
        n = 0;
        while (!kbd_fail && n < 600) begin
            @(negedge mclk);
            n++;
        end
        chk("to_kbd_fail", 32'(kbd_fail), 32'd1);
        chk("to_init_done", 32'(init_done), 32'd0);
        chk("to_ff_count", 32'(sent_q.size()), 32'd4);
        if (sent_q.size() >= 2) begin
            chk("to_ff_byte", 32'(sent_q[1]), 32'hFF);
            chk("to_gap", 32'(sent_t[1] - sent_t[0]), 32'd69);
        end
        idle(100);
        chk("to_no_more_tx", 32'(sent_q.size()), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
